// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: DRP read-modify-write engine that reprograms MMCM divide
// fields (CLKOUT0..N-1, CLKFBOUT, DIVCLK) while the MMCM is held in reset,
// then waits for LOCKED.
// Optional build macro: DFS_DRP_READBACK_VERIFY_EN adds a readback compare
// after every DRP write and the err_verify output.
module mmcm_drp_reconfig #(
    parameter int unsigned NUM_CLKOUT     = 2,
    parameter int unsigned DRP_ADDR_WIDTH = 7,
    parameter int unsigned DRP_DATA_WIDTH = 16,
    parameter int unsigned DRP_TIMEOUT    = 1023,
    parameter int unsigned LOCK_TIMEOUT   = 65535
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NUM_CLKOUT+1:0]       req_mask,
    input  logic [7*NUM_CLKOUT-1:0]     req_clkout_div,
    input  logic [6:0]                  req_fb_div,
    input  logic [6:0]                  req_div_div,
    output logic                        done,
    output logic                        err_range,
    output logic                        err_timeout,
`ifdef DFS_DRP_READBACK_VERIFY_EN
    output logic                        err_verify,
`endif
    output logic                        busy,
    output logic                        drp_den,
    output logic                        drp_dwe,
    output logic [DRP_ADDR_WIDTH-1:0]   drp_daddr,
    output logic [DRP_DATA_WIDTH-1:0]   drp_di,
    input  logic [DRP_DATA_WIDTH-1:0]   drp_do,
    input  logic                        drp_drdy,
    output logic                        mmcm_rst,
    input  logic                        mmcm_locked
);

    // Slot s < 2N: CLKOUT(s/2) REG1/REG2; 2N/2N+1: FBOUT REG1/REG2; 2N+2: DIVCLK
    localparam int unsigned NSLOT   = 2 * NUM_CLKOUT + 3;
    localparam int unsigned SLOT_W  = $clog2(NSLOT);
    localparam int unsigned TMR_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned DW      = DRP_DATA_WIDTH;

    localparam logic [7:0] CLK_BASE [7] = '{8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h06, 8'h12};

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
`ifdef DFS_DRP_READBACK_VERIFY_EN
        S_VRD, S_VRD_WAIT,
`endif
        S_RST_OFF, S_LOCK_WAIT, S_DONE
    } state_t;

    state_t                    state_q;
    logic [NUM_CLKOUT+1:0]     mask_q;
    logic [7*NUM_CLKOUT-1:0]   cdiv_q;
    logic [6:0]                fbdiv_q;
    logic [6:0]                dvdiv_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [TMR_W-1:0]          timer_q;
    logic                      ready_q, done_q, err_range_q, err_timeout_q, busy_q;
    logic                      den_q, dwe_q, rst_q;
    logic [DRP_ADDR_WIDTH-1:0] daddr_q;
    logic [DW-1:0]             di_q;
`ifdef DFS_DRP_READBACK_VERIFY_EN
    logic                      err_verify_q;
`endif

    logic [NSLOT-1:0]  slot_mask_c;
    logic [SLOT_W-1:0] first_slot_c;
    logic [SLOT_W-1:0] nxt_slot_c;
    logic              nxt_found_c;
    logic [6:0]        cur_div_c;
    logic              cur_is_div_c;
    logic              range_err_c;
    logic              drp_to_c;
    logic              lock_to_c;

    // DRP address of a register slot
    function automatic logic [DRP_ADDR_WIDTH-1:0] slot_addr(input logic [SLOT_W-1:0] s);
        logic [7:0] a;
        a = 8'h16;
        if (s < SLOT_W'(2 * NUM_CLKOUT)) begin
            for (int c = 0; c < NUM_CLKOUT; c++) begin
                if (s[SLOT_W-1:1] == (SLOT_W-1)'(c)) a = CLK_BASE[c] | {7'd0, s[0]};
            end
        end else if (s != SLOT_W'(2 * NUM_CLKOUT + 2)) begin
            a = 8'h14 | {7'd0, s[0]};
        end
        return DRP_ADDR_WIDTH'(a);
    endfunction

    // Merge divide value fields into the word read back from the DRP
    function automatic logic [DW-1:0] drp_merge(input logic [DW-1:0] rd, input logic [6:0] d,
                                                input logic is_div, input logic reg2);
        logic [DW-1:0] m;
        logic [5:0]    hi;
        logic [5:0]    lo;
        logic          edge_b;
        logic          nc;
        hi     = d[6:1];
        lo     = 6'(d - {1'b0, d[6:1]});
        if (d == 7'd1) begin
            hi = 6'd1;
            lo = 6'd1;
        end
        edge_b = d[0];
        nc     = (d == 7'd1);
        m      = rd;
        if (is_div) begin
            m[13]   = edge_b;
            m[12]   = nc;
            m[11:6] = hi;
            m[5:0]  = lo;
        end else if (reg2) begin
            m[11] = 1'b0;
            m[7]  = edge_b;
            m[6]  = nc;
        end else begin
            m[11:6] = hi;
            m[5:0]  = lo;
        end
        return m;
    endfunction

    // Expand field mask to register slots and find first / next enabled slot
    always_comb begin
        slot_mask_c  = '0;
        first_slot_c = '0;
        nxt_slot_c   = '0;
        nxt_found_c  = 1'b0;
        for (int s = 0; s < 2 * NUM_CLKOUT; s++) slot_mask_c[s] = mask_q[s/2];
        slot_mask_c[2*NUM_CLKOUT]   = mask_q[NUM_CLKOUT];
        slot_mask_c[2*NUM_CLKOUT+1] = mask_q[NUM_CLKOUT];
        slot_mask_c[2*NUM_CLKOUT+2] = mask_q[NUM_CLKOUT+1];
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if (slot_mask_c[s]) first_slot_c = SLOT_W'(s);
            if (slot_mask_c[s] && (SLOT_W'(s) > slot_q)) begin
                nxt_slot_c  = SLOT_W'(s);
                nxt_found_c = 1'b1;
            end
        end
    end

    // Divide value and register kind of the current slot
    always_comb begin
        cur_is_div_c = (slot_q == SLOT_W'(2 * NUM_CLKOUT + 2));
        cur_div_c    = cur_is_div_c ? dvdiv_q : fbdiv_q;
        if (slot_q < SLOT_W'(2 * NUM_CLKOUT)) begin
            for (int c = 0; c < NUM_CLKOUT; c++) begin
                if (slot_q[SLOT_W-1:1] == (SLOT_W-1)'(c)) cur_div_c = cdiv_q[7*c +: 7];
            end
        end
    end

    // Range check of every masked divide value (legal 1..126)
    always_comb begin
        range_err_c = 1'b0;
        for (int c = 0; c < NUM_CLKOUT; c++) begin
            if (mask_q[c] && (cdiv_q[7*c +: 7] == 7'd0 || cdiv_q[7*c +: 7] == 7'd127))
                range_err_c = 1'b1;
        end
        if (mask_q[NUM_CLKOUT] && (fbdiv_q == 7'd0 || fbdiv_q == 7'd127)) range_err_c = 1'b1;
        if (mask_q[NUM_CLKOUT+1] && (dvdiv_q == 7'd0 || dvdiv_q == 7'd127)) range_err_c = 1'b1;
    end

    assign drp_to_c  = (timer_q == TMR_W'(DRP_TIMEOUT - 1));
    assign lock_to_c = (timer_q == TMR_W'(LOCK_TIMEOUT - 1));

    // Reconfiguration sequencer with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            cdiv_q        <= '0;
            fbdiv_q       <= '0;
            dvdiv_q       <= '0;
            slot_q        <= '0;
            timer_q       <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            den_q         <= 1'b0;
            dwe_q         <= 1'b0;
            rst_q         <= 1'b0;
            daddr_q       <= '0;
            di_q          <= '0;
`ifdef DFS_DRP_READBACK_VERIFY_EN
            err_verify_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        mask_q        <= req_mask;
                        cdiv_q        <= req_clkout_div;
                        fbdiv_q       <= req_fb_div;
                        dvdiv_q       <= req_div_div;
                        err_range_q   <= 1'b0;
                        err_timeout_q <= 1'b0;
`ifdef DFS_DRP_READBACK_VERIFY_EN
                        err_verify_q  <= 1'b0;
`endif
                        busy_q        <= 1'b1;
                        ready_q       <= 1'b0;
                        state_q       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (range_err_c) begin
                        err_range_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (mask_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rst_q   <= 1'b1;
                        slot_q  <= first_slot_c;
                        state_q <= S_RST_ON;
                    end
                end
                S_RST_ON: begin
                    den_q   <= 1'b1;
                    daddr_q <= slot_addr(slot_q);
                    state_q <= S_RD;
                end
                S_RD: begin
                    timer_q <= '0;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (drp_drdy) begin
                        di_q    <= drp_merge(drp_do, cur_div_c, cur_is_div_c, slot_q[0]);
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= S_WR;
                    end else if (drp_to_c) begin
                        rst_q         <= 1'b0;
                        err_timeout_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_WR: begin
                    timer_q <= '0;
                    state_q <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_drdy) begin
`ifdef DFS_DRP_READBACK_VERIFY_EN
                        den_q   <= 1'b1;
                        state_q <= S_VRD;
`else
                        if (nxt_found_c) begin
                            slot_q  <= nxt_slot_c;
                            daddr_q <= slot_addr(nxt_slot_c);
                            den_q   <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            rst_q   <= 1'b0;
                            state_q <= S_RST_OFF;
                        end
`endif
                    end else if (drp_to_c) begin
                        rst_q         <= 1'b0;
                        err_timeout_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`ifdef DFS_DRP_READBACK_VERIFY_EN
                S_VRD: begin
                    timer_q <= '0;
                    state_q <= S_VRD_WAIT;
                end
                S_VRD_WAIT: begin
                    if (drp_drdy) begin
                        if (drp_do != di_q) begin
                            err_verify_q <= 1'b1;
                            rst_q        <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (nxt_found_c) begin
                            slot_q  <= nxt_slot_c;
                            daddr_q <= slot_addr(nxt_slot_c);
                            den_q   <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            rst_q   <= 1'b0;
                            state_q <= S_RST_OFF;
                        end
                    end else if (drp_to_c) begin
                        rst_q         <= 1'b0;
                        err_timeout_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
`endif
                S_RST_OFF: begin
                    timer_q <= '0;
                    state_q <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    if (mmcm_locked) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (lock_to_c) begin
                        err_timeout_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign done        = done_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;
    assign busy        = busy_q;
    assign drp_den     = den_q;
    assign drp_dwe     = dwe_q;
    assign drp_daddr   = daddr_q;
    assign drp_di      = di_q;
    assign mmcm_rst    = rst_q;
`ifdef DFS_DRP_READBACK_VERIFY_EN
    assign err_verify  = err_verify_q;
`endif

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig: DRP memory model, MMCM lock model and
// a write scoreboard of expected (address, data) pairs.
module tb_mmcm_drp_reconfig;

    localparam int unsigned N      = 2;
    localparam int unsigned DTO    = 20;
    localparam int unsigned LTO    = 100;
    localparam int          LIMIT  = 600;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [N+1:0]      req_mask;
    logic [7*N-1:0]    req_clkout_div;
    logic [6:0]        req_fb_div;
    logic [6:0]        req_div_div;
    logic              done, err_range, err_timeout, busy;
    logic              drp_den, drp_dwe;
    logic [6:0]        drp_daddr;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_drdy;
    logic              mmcm_rst;
    logic              mmcm_locked;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [6:0] a; logic [15:0] d; } wr_t;
    wr_t exp_q[$];

    logic [15:0] mem [128];
    int          pend;
    logic [6:0]  pend_addr;
    logic        pend_wr;
    bit          drdy_en   = 1'b1;
    bit          lock_hold = 1'b0;
    int          lock_delay = 10;
    int          lk_cnt;
    int          den_cnt;
    bit          rst_seen;
    int          cyc;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(
        .NUM_CLKOUT(N), .DRP_ADDR_WIDTH(7), .DRP_DATA_WIDTH(16),
        .DRP_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
        .req_clkout_div(req_clkout_div), .req_fb_div(req_fb_div), .req_div_div(req_div_div),
        .done(done), .err_range(err_range), .err_timeout(err_timeout), .busy(busy),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // DRP slave: fixed 2-cycle drdy latency, optional silence; scoreboards writes
    always @(negedge clk) begin
        drp_drdy = 1'b0;
        if (!rstn) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy = 1'b1;
                    if (!pend_wr) drp_do = mem[pend_addr];
                end
            end
            if (drp_den) begin
                den_cnt++;
                chk("rst_during_drp", mmcm_rst, 1);
                if (drp_dwe) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {drp_daddr, drp_di}, 0);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", drp_daddr, e.a);
                        chk("wr_data", drp_di, e.d);
                    end
                    mem[drp_daddr] = drp_di;
                end
                pend_addr = drp_daddr;
                pend_wr   = drp_dwe;
                if (drdy_en) pend = 2;
            end
            if (mmcm_rst) rst_seen = 1'b1;
        end
    end

    // MMCM lock model: unlocked while in reset, locks lock_delay cycles after release
    always @(negedge clk) begin
        if (!rstn || mmcm_rst || lock_hold) begin
            mmcm_locked = 1'b0;
            lk_cnt      = 0;
        end else if (!mmcm_locked) begin
            if (lk_cnt >= lock_delay) mmcm_locked = 1'b1;
            else lk_cnt++;
        end
    end

    task automatic do_req(input logic [3:0] m, input logic [6:0] c0, input logic [6:0] c1,
                          input logic [6:0] fb, input logic [6:0] dv);
        @(negedge clk);
        chk("ready_before", req_ready, 1);
        den_cnt        = 0;
        rst_seen       = 1'b0;
        req_valid      = 1'b1;
        req_mask       = m;
        req_clkout_div = {c1, c0};
        req_fb_div     = fb;
        req_div_div    = dv;
        @(negedge clk);
        req_valid      = 1'b0;
        req_mask       = '1;
        req_clkout_div = '0;
        req_fb_div     = 7'd0;
        req_div_div    = 7'd127;
        cyc = 1;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic post_done(input logic exp_rng, input logic exp_to);
        chk("err_range", err_range, exp_rng);
        chk("err_timeout", err_timeout, exp_to);
        chk("rst_at_done", mmcm_rst, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_after", req_ready, 1);
        chk("busy_after", busy, 0);
        chk("err_range_held", err_range, exp_rng);
        chk("err_timeout_held", err_timeout, exp_to);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic preset_t1();
        mem[7'h08] = 16'hE000;
        mem[7'h09] = 16'h1C00;
        push_wr(7'h08, 16'hE083);
        push_wr(7'h09, 16'h1480);
    endtask

    task automatic preset_t2();
        mem[7'h08] = 16'hFFFF; mem[7'h09] = 16'hFFFF;
        mem[7'h0A] = 16'h0000; mem[7'h0B] = 16'h0000;
        mem[7'h14] = 16'h1000; mem[7'h15] = 16'h0800;
        mem[7'h16] = 16'h0000;
        push_wr(7'h08, 16'hF082);
        push_wr(7'h09, 16'hF73F);
        push_wr(7'h0A, 16'h0041);
        push_wr(7'h0B, 16'h00C0);
        push_wr(7'h14, 16'h1145);
        push_wr(7'h15, 16'h0000);
        push_wr(7'h16, 16'h3041);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        pend = 0; den_cnt = 0; rst_seen = 1'b0; lk_cnt = 0;
        drp_do = '0; drp_drdy = 1'b0; mmcm_locked = 1'b0;
        rstn = 1'b0; req_valid = 1'b0; req_mask = '0; req_clkout_div = '0;
        req_fb_div = '0; req_div_div = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_den", drp_den, 0);
        chk("rst_mmcm_rst", mmcm_rst, 0);
        chk("rst_errs", {err_range, err_timeout, drp_dwe}, 0);
        chk("rst_addr_di", {drp_daddr, drp_di}, 0);
        rstn = 1'b1;
        repeat (15) @(negedge clk);

        // single CLKOUT0 channel, div 5
        preset_t1();
        do_req(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
        chk("t1_den_cnt", den_cnt, 4);
        chk("t1_rst_seen", rst_seen, 1);
        post_done(1'b0, 1'b0);

        // all fields, six RMW pairs plus DIVCLK
        preset_t2();
        do_req(4'b1111, 7'd4, 7'd1, 7'd10, 7'd1);
        chk("t2_den_cnt", den_cnt, 14);
        post_done(1'b0, 1'b0);

        // out-of-range masked value 0
        do_req(4'b0001, 7'd0, 7'd5, 7'd5, 7'd5);
        chk("rng0_cycles", cyc, 2);
        chk("rng0_den", den_cnt, 0);
        chk("rng0_rst", rst_seen, 0);
        post_done(1'b1, 1'b0);

        // out-of-range masked FBOUT 127
        do_req(4'b0100, 7'd5, 7'd5, 7'd127, 7'd5);
        chk("rng127_cycles", cyc, 2);
        chk("rng127_den", den_cnt, 0);
        post_done(1'b1, 1'b0);

        // empty mask: immediate done, error flags cleared by accept
        do_req(4'b0000, 7'd5, 7'd5, 7'd5, 7'd5);
        chk("mask0_cycles", cyc, 2);
        chk("mask0_den", den_cnt, 0);
        chk("mask0_rst", rst_seen, 0);
        post_done(1'b0, 1'b0);

        // unmasked illegal value ignored; max legal divide 126
        mem[7'h0A] = 16'h0000; mem[7'h0B] = 16'h0000;
        push_wr(7'h0A, 16'h0FFF);
        push_wr(7'h0B, 16'h0000);
        do_req(4'b0010, 7'd0, 7'd126, 7'd0, 7'd0);
        chk("d126_den", den_cnt, 4);
        post_done(1'b0, 1'b0);

        // DRP never answers
        drdy_en = 1'b0;
        do_req(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
        chk("drp_to_window", (cyc >= DTO) && (cyc <= DTO + 8), 1);
        chk("drp_to_den", den_cnt, 1);
        post_done(1'b0, 1'b1);
        drdy_en = 1'b1;

        // MMCM never locks
        lock_hold = 1'b1;
        preset_t1();
        do_req(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
        chk("lock_to_window", (cyc >= LTO) && (cyc <= LTO + 60), 1);
        post_done(1'b0, 1'b1);
        lock_hold = 1'b0;
        repeat (15) @(negedge clk);

        // async reset during the first WR_WAIT
        preset_t2();
        @(negedge clk);
        req_valid = 1'b1; req_mask = 4'b1111;
        req_clkout_div = {7'd1, 7'd4}; req_fb_div = 7'd10; req_div_div = 7'd1;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!(drp_den && drp_dwe) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("wr_reached", drp_den && drp_dwe, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_mmcm_rst", mmcm_rst, 0);
        chk("arst_den", {drp_den, drp_dwe, done}, 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("arst_ready_next", req_ready, 1);
        chk("arst_rst_next", mmcm_rst, 0);
        repeat (15) @(negedge clk);

        // recovery after abort
        preset_t1();
        do_req(4'b0001, 7'd5, 7'd0, 7'd0, 7'd0);
        chk("rec_den_cnt", den_cnt, 4);
        post_done(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
